// File: rtl/core_ex_bj_ctrl_pkg.sv
// Shared types for the EX-stage branch/jump redirect controller.
// Holds the FSM state encoding and the performance counter width.
package core_ex_bj_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REDIR = 2'b01,
        ST_FLUSH = 2'b10
    } bj_state_e;

    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/core_ex_bj_ctrl_perf_cnt.sv
// Free-running event counter with increment enable and a synchronous load.
// Wraps modulo 2^W. Reset is asynchronous and active-high.
module core_perf_cnt
    import core_ex_bj_ctrl_pkg::*;
#(
    parameter int W = PERF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/core_ex_bj_ctrl.sv
// EX-stage branch/jump controller: turns a taken resolve into an IFU redirect
// handshake followed by a fixed number of IF/ID flush cycles.
module core_ex_bj_ctrl
    import core_ex_bj_ctrl_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_is_bj,
    input  logic            branch_jump,
    input  logic [PC_W-1:0] bj_pc,
    output logic            redir_valid,
    output logic [PC_W-1:0] redir_pc,
    input  logic            redir_ready,
    output logic            flush_ifid,
    output logic            ex_stall,
    output logic            misalign_exc,
    output logic [PC_W-1:0] misalign_tval,
    output logic [31:0]     bj_cnt,
    output logic [31:0]     taken_cnt
);

    localparam int              FC_W     = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LOAD  = FC_W'(FLUSH_CYCLES);
    localparam logic [PC_W-1:0] MIS_MASK = PC_W'(3);
    localparam bit              NO_FLUSH = (FLUSH_CYCLES == 0);

    bj_state_e       state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic [PC_W-1:0] redir_pc_q, redir_pc_d;
    logic            mis_exc_q, mis_exc_d;
    logic [PC_W-1:0] mis_tval_q, mis_tval_d;

    logic resolve;
    logic misaligned;
    logic take_redir;
    logic take_exc;

    // Resolve inputs only count while idle; anything presented during a redirect is dropped.
    assign resolve    = ex_valid & ex_is_bj & (state_q == ST_IDLE);
    assign misaligned = |(bj_pc & MIS_MASK);
    assign take_redir = resolve & branch_jump & ~misaligned;
    assign take_exc   = resolve & branch_jump & misaligned;

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        redir_pc_d = redir_pc_q;
        mis_exc_d  = 1'b0;
        mis_tval_d = mis_tval_q;
        case (state_q)
            ST_IDLE: begin
                if (take_redir) begin
                    redir_pc_d = bj_pc;
                    state_d    = ST_REDIR;
                end
                if (take_exc) begin
                    mis_exc_d  = 1'b1;
                    mis_tval_d = bj_pc;
                end
            end
            ST_REDIR: begin
                if (redir_ready) begin
                    if (NO_FLUSH) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FC_LOAD;
                    end
                end
            end
            ST_FLUSH: begin
                fcnt_d = fcnt_q - FC_W'(1);
                if (fcnt_q <= FC_W'(1)) begin
                    state_d = ST_IDLE;
                    fcnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fcnt_q     <= '0;
            redir_pc_q <= '0;
            mis_exc_q  <= 1'b0;
            mis_tval_q <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            redir_pc_q <= redir_pc_d;
            mis_exc_q  <= mis_exc_d;
            mis_tval_q <= mis_tval_d;
        end
    end

    assign redir_valid   = (state_q == ST_REDIR);
    assign flush_ifid    = (state_q != ST_IDLE);
    assign ex_stall      = (state_q != ST_IDLE);
    assign redir_pc      = redir_pc_q;
    assign misalign_exc  = mis_exc_q;
    assign misalign_tval = mis_tval_q;

    core_perf_cnt #(.W(32)) u_bj_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (resolve),
        .ld_i     (1'b0),
        .ld_val_i (32'd0),
        .cnt_o    (bj_cnt)
    );

    core_perf_cnt #(.W(32)) u_taken_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (resolve & branch_jump),
        .ld_i     (1'b0),
        .ld_val_i (32'd0),
        .cnt_o    (taken_cnt)
    );

endmodule
